// File: rtl/sfr_pkg.sv
// Shared definitions for the SFR read responder and its address decoder.
// Optional build macro: SFR_RD_ERR_EN (miss returns an error flag and pattern).
package sfr_pkg;

  localparam int N_SFR       = 14;
  localparam int SFR_DW      = 64;
  localparam int SFR_AW      = 32;
  localparam int SFR_IDX_LSB = 20;

  // 32-bit word replicated across the data width on an unmapped read.
  localparam logic [31:0] SFR_ERR_PATTERN = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOOKUP = 2'd1,
    ST_RESP   = 2'd2
  } sfr_state_t;

  // Width of a 0-based SFR slot number (at least one bit).
  function automatic int sfr_slot_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sfr_addr_index.sv
// Combinational address decode: {idx, zeros} -> hit flag and 0-based slot.
// Index 1..N_SFR maps to slot 0..N_SFR-1; index 0, out-of-range indices and
// any set bit below IDX_LSB are misses. Shared with the write-side decoder.
module sfr_addr_index
  import sfr_pkg::*;
#(
  parameter int AW      = SFR_AW,
  parameter int IDX_LSB = SFR_IDX_LSB,
  parameter int NSFR    = N_SFR,
  parameter int IW      = sfr_slot_width(N_SFR)
) (
  input  logic [AW-1:0] addr,
  output logic          hit,
  output logic [IW-1:0] slot
);

  localparam int XW = AW - IDX_LSB;

  logic [XW-1:0] idx;
  logic [XW-1:0] slot_full;
  logic          low_zero;
  logic          in_range;

  // Split the address, range-check the index and form the slot number.
  always_comb begin
    idx       = addr[AW-1:IDX_LSB];
    low_zero  = (addr[IDX_LSB-1:0] == '0);
    in_range  = (idx != '0) && (idx <= XW'(NSFR));
    hit       = low_zero && in_range;
    slot_full = idx - XW'(1);
    if (hit) begin
      slot = slot_full[IW-1:0];
    end else begin
      slot = '0;
    end
  end

endmodule

// File: rtl/sfr_read_responder.sv
// Serves CPU loads from the memory-mapped SFR window with valid/ready on both
// the request and response side. One read in flight: IDLE -> LOOKUP -> RESP.
// Optional build macro: SFR_RD_ERR_EN -- when defined a miss sets resp_err and
// returns the replicated 0xDEADBEEF pattern; otherwise a miss returns zero.
module sfr_read_responder
  import sfr_pkg::*;
#(
  parameter int N_SFR_P = N_SFR,
  parameter int DW      = SFR_DW,
  parameter int AW      = SFR_AW,
  parameter int IDX_LSB = SFR_IDX_LSB
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [AW-1:0]         req_addr,
  input  logic [N_SFR_P*DW-1:0] sfr_bus,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DW-1:0]         resp_data,
  output logic                  resp_hit,
  output logic                  resp_err,
  output logic [15:0]           miss_count
);

  localparam int IW = sfr_slot_width(N_SFR_P);

`ifdef SFR_RD_ERR_EN
  localparam logic [DW-1:0] MISS_DATA = {(DW/32){SFR_ERR_PATTERN}};
  localparam logic          MISS_ERR  = 1'b1;
`else
  localparam logic [DW-1:0] MISS_DATA = '0;
  localparam logic          MISS_ERR  = 1'b0;
`endif

  sfr_state_t    state;
  sfr_state_t    nxt;
  logic [AW-1:0] addr_q;
  logic          dec_hit;
  logic [IW-1:0] dec_slot;
  logic [DW-1:0] sel_data;

  sfr_addr_index #(
    .AW      (AW),
    .IDX_LSB (IDX_LSB),
    .NSFR    (N_SFR_P),
    .IW      (IW)
  ) u_index (
    .addr (addr_q),
    .hit  (dec_hit),
    .slot (dec_slot)
  );

  // Pick the addressed SFR out of the flattened bus.
  always_comb begin
    sel_data = sfr_bus[int'(dec_slot)*DW +: DW];
  end

  // Next-state logic: accept in IDLE, one decode cycle, hold RESP until taken.
  always_comb begin
    nxt = state;
    case (state)
      ST_IDLE: begin
        if (req_valid && req_ready) begin
          nxt = ST_LOOKUP;
        end else begin
          nxt = ST_IDLE;
        end
      end
      ST_LOOKUP: nxt = ST_RESP;
      ST_RESP: begin
        if (resp_ready) begin
          nxt = ST_IDLE;
        end else begin
          nxt = ST_RESP;
        end
      end
      default: nxt = ST_IDLE;
    endcase
  end

  // State register with registered handshake outputs derived from next state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      req_ready  <= 1'b0;
      resp_valid <= 1'b0;
    end else begin
      state      <= nxt;
      req_ready  <= (nxt == ST_IDLE);
      resp_valid <= (nxt == ST_RESP);
    end
  end

  // Latch the request address on acceptance.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      addr_q <= '0;
    end else if (state == ST_IDLE && req_valid && req_ready) begin
      addr_q <= req_addr;
    end
  end

  // Snapshot SFR data and hit/err at the end of LOOKUP; held through RESP.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      resp_data <= '0;
      resp_hit  <= 1'b0;
      resp_err  <= 1'b0;
    end else if (state == ST_LOOKUP) begin
      resp_data <= dec_hit ? sel_data : MISS_DATA;
      resp_hit  <= dec_hit;
      resp_err  <= ~dec_hit & MISS_ERR;
    end
  end

  // Saturating count of miss responses actually taken by the consumer.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      miss_count <= 16'h0000;
    end else if (state == ST_RESP && resp_ready && !resp_hit &&
                 miss_count != 16'hFFFF) begin
      miss_count <= miss_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_sfr_read_responder.sv
// Randomized self-checking bench for sfr_read_responder against a simple
// address-rule model (SFR word array, integer miss counter).
module tb_sfr_read_responder;

  localparam int NS = 14;

`ifdef SFR_RD_ERR_EN
  localparam logic [63:0] EXP_MISS_DATA = 64'hDEAD_BEEF_DEAD_BEEF;
  localparam logic        EXP_MISS_ERR  = 1'b1;
`else
  localparam logic [63:0] EXP_MISS_DATA = 64'h0;
  localparam logic        EXP_MISS_ERR  = 1'b0;
`endif

  logic           clock = 1'b0;
  logic           reset;
  logic           req_valid;
  logic           req_ready;
  logic [31:0]    req_addr;
  logic [NS*64-1:0] sfr_bus;
  logic           resp_valid;
  logic           resp_ready;
  logic [63:0]    resp_data;
  logic           resp_hit;
  logic           resp_err;
  logic [15:0]    miss_count;

  logic [63:0]    words [NS];
  int             n_chk = 0;
  int             n_bad = 0;
  int             exp_miss = 0;

  sfr_read_responder dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .sfr_bus    (sfr_bus),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_hit   (resp_hit),
    .resp_err   (resp_err),
    .miss_count (miss_count)
  );

  always #5 clock = ~clock;

  // SFR k (1-based) sits at word k-1 of the flattened bus.
  always_comb begin
    sfr_bus = '0;
    for (int i = 0; i < NS; i++) sfr_bus[i*64 +: 64] = words[i];
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic scramble_words();
    for (int i = 0; i < NS; i++) words[i] = {$urandom, $urandom};
  endtask

  // One complete read: handshake, latency, data, stall stability, completion.
  task automatic do_read(input logic [31:0] addr, input int stall, input bit scramble);
    bit          acc;
    bit          eh;
    int          idx;
    logic [63:0] ed;
    @(negedge clock);
    req_valid  = 1'b1;
    req_addr   = addr;
    resp_ready = 1'b0;
    acc = 1'b0;
    for (int t = 0; t < 20; t++) begin
      if (req_ready) begin
        acc = 1'b1;
        break;
      end
      @(negedge clock);
    end
    check("accept", {63'b0, acc}, 64'd1);
    if (!acc) begin
      req_valid = 1'b0;
      return;
    end
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    req_addr  = $urandom;
    check("lookup_valid", {63'b0, resp_valid}, 64'd0);
    check("lookup_ready", {63'b0, req_ready}, 64'd0);
    if (scramble) scramble_words();
    idx = int'(addr >> 20);
    eh  = (addr % 32'h0010_0000 == 32'd0) && (idx >= 1) && (idx <= NS);
    ed  = eh ? words[idx-1] : EXP_MISS_DATA;
    @(negedge clock);
    check("resp_valid", {63'b0, resp_valid}, 64'd1);
    check("resp_data", resp_data, ed);
    check("resp_hit", {63'b0, resp_hit}, {63'b0, eh});
    check("resp_err", {63'b0, resp_err}, {63'b0, (!eh) & EXP_MISS_ERR});
    if (scramble) scramble_words();
    for (int s = 0; s < stall; s++) begin
      req_valid = 1'($urandom_range(0, 1));
      words[$urandom_range(0, NS-1)] = {$urandom, $urandom};
      @(negedge clock);
      check("stall_valid", {63'b0, resp_valid}, 64'd1);
      check("stall_data", resp_data, ed);
      check("stall_ready", {63'b0, req_ready}, 64'd0);
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    if (!eh && exp_miss < 65535) exp_miss++;
    @(negedge clock);
    resp_ready = 1'b0;
    check("done_valid", {63'b0, resp_valid}, 64'd0);
    check("done_ready", {63'b0, req_ready}, 64'd1);
    check("miss_count", {48'b0, miss_count}, 64'(exp_miss));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_req_ready"}, {63'b0, req_ready}, 64'd0);
    check({tag, "_resp_valid"}, {63'b0, resp_valid}, 64'd0);
    check({tag, "_resp_data"}, resp_data, 64'd0);
    check({tag, "_resp_hit"}, {63'b0, resp_hit}, 64'd0);
    check({tag, "_resp_err"}, {63'b0, resp_err}, 64'd0);
    check({tag, "_miss_count"}, {48'b0, miss_count}, 64'd0);
  endtask

  initial begin
    logic [31:0] a;
    int          kind;
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_addr   = 32'h0;
    resp_ready = 1'b0;
    for (int i = 0; i < NS; i++) words[i] = 64'h0;
    repeat (2) @(negedge clock);
    check_all_zero("rst");
    reset = 1'b0;
    @(negedge clock);
    check("post_rst_ready", {63'b0, req_ready}, 64'd1);

    // Directed: hit on SFR3, low-bit miss, index 0 and index 15 misses.
    words[2] = 64'h0123_4567_89AB_CDEF;
    do_read(32'h0030_0000, 0, 1'b0);
    do_read(32'h0030_0004, 0, 1'b0);
    do_read(32'h0000_0000, 0, 1'b0);
    do_read(32'h00F0_0000, 0, 1'b0);

    // Long backpressure while the SFR bus keeps changing.
    scramble_words();
    do_read(32'h0070_0000, 10, 1'b1);

    // Randomized reads over hits, index 0, high indices and low-bit misses.
    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 3);
      case (kind)
        0, 1: a = {12'($urandom_range(1, NS)), 20'h0};
        2:    a = {12'($urandom_range(NS + 1, 4095)), 20'h0};
        default: a = {12'($urandom_range(0, NS)), 20'($urandom_range(1, 20'hFFFFF))};
      endcase
      do_read(a, $urandom_range(0, 3), 1'b1);
    end

    // Reset during LOOKUP drops the request and clears the counter.
    @(negedge clock);
    req_valid = 1'b1;
    req_addr  = 32'h0000_0000;
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    check("pre_rst_lookup_valid", {63'b0, resp_valid}, 64'd0);
    reset = 1'b1;
    #1;
    check_all_zero("mid_rst");
    @(negedge clock);
    reset    = 1'b0;
    exp_miss = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      check("post_rst_no_resp", {63'b0, resp_valid}, 64'd0);
    end
    do_read(32'h00E0_0000, 1, 1'b1);

    // Saturation: preset the counter near the top, then drive misses past it.
    @(negedge clock);
    force dut.miss_count = 16'hFFFD;
    @(negedge clock);
    release dut.miss_count;
    exp_miss = 65533;
    @(negedge clock);
    check("preset_count", {48'b0, miss_count}, 64'h0000_0000_0000_FFFD);
    do_read(32'h00F0_0000, 0, 1'b0);
    do_read(32'h0010_0001, 0, 1'b0);
    do_read(32'h0000_0000, 0, 1'b0);
    do_read(32'h0010_0000, 0, 1'b0);
    check("sat_final", {48'b0, miss_count}, 64'h0000_0000_0000_FFFF);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
